ram_rd_arbiter: RTL and testbench
=================================

Name: ram_rd_arbiter

Overview:
- Two-requester read arbiter in front of the single-port simulation RAM read channel.
- Accepts AR requests from master 0 (instruction fetch) and master 1 (data/load), grants one at a time with round-robin priority, and forwards it to the RAM slave port.
- Routes the returned R beat back to the owning master.
- Exactly one transaction outstanding at a time; the RAM behaves the same as with a single direct master.

Parameters:
- DW, 128, data width in bits (one RAM line).
- AW, 16, byte address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low: state is reset on a rising clk edge while rst==0.
- m0_arValid  in  1  master 0 read-address valid.
- m0_arReady  out  1  master 0 read-address accepted.
- m0_arAddr  in  AW  master 0 byte address.
- m0_rValid  out  1  master 0 read data valid.
- m0_rReady  in  1  master 0 ready for data.
- m0_rData  out  DW  master 0 read data.
- m1_arValid, m1_arReady, m1_arAddr, m1_rValid, m1_rReady, m1_rData: same as m0_*, for master 1.
- s_arValid  out  1  to RAM arValid.
- s_arReady  in  1  from RAM arReady.
- s_arAddr  out  AW  to RAM arAddr.
- s_rValid  in  1  from RAM rValid.
- s_rReady  out  1  to RAM rReady.
- s_rData  in  DW  from RAM rData.
- busy  out  1  1 whenever state != IDLE.
- owner  out  1  id of the master owning the current transaction; valid when busy.

Behaviour:
- States: IDLE, ADDR, DATA (2-bit encoding). Registered: state, owner, addr_q[AW-1:0], prio (1 bit, id of the highest-priority master).
- Reset (rst==0 at a clock edge) gives state=IDLE, prio=0, owner=0, addr_q=0.
  - Hence after reset: all m*_arReady=0 unless a request is pending in IDLE; all m*_rValid=0; s_arValid=0; s_rReady=0; busy=0.
- Grant, combinational in IDLE only:
  - If only one m*_arValid is high, that master wins.
  - If both are high, master prio wins.
  - m{i}_arReady = (state==IDLE) & winner==i. The other master's arReady stays 0.
- IDLE to ADDR on any m*_arValid: owner<=winner, addr_q<=winner's arAddr.
- ADDR:
  - s_arValid=1, s_arAddr=addr_q.
  - On s_arValid & s_arReady: go to DATA.
  - s_arValid holds, with a stable address, until accepted.
- DATA:
  - m{owner}_rValid = s_rValid; s_rReady = m{owner}_rReady.
  - The non-owner has rValid=0, and its rReady is ignored.
  - On s_rValid & s_rReady: state<=IDLE, prio<=~owner (last winner drops to lowest priority).
- m0_rData and m1_rData are both driven with s_rData at all times; qualify them with rValid.
- Latency: AR accepted at edge N enters ADDR; s_arValid asserts in cycle N+1. With the RAM's fixed timing (accepts in IDLE, data valid next cycle), the master sees rValid at cycle N+2 at the earliest.
- Minimum turnaround: one IDLE cycle between transactions. Peak throughput is 1 transaction per 3 cycles.
- No requests in IDLE: remain in IDLE, prio unchanged.
- A master deasserting arValid before its arReady is legal; no grant is recorded for it.
- New requests arriving while busy are held off (arReady=0) until the return to IDLE.
- Reset mid-operation (ADDR or DATA): state returns to IDLE, and any in-flight RAM response is discarded.
  - The RAM shares clk and is reset in the same cycle, so no stale R beat follows.
- Requests are never reordered, and a returned beat is never delivered to the wrong master.

Test Plan:
- Single request: m0_arValid=1, m0_arAddr=0x0010, RAM line 1 = 0x...AA -> m0_arReady=1 in cycle 0, s_arValid/s_arAddr=0x0010 in cycle 1, m0_rValid=1 with m0_rData=0x...AA in cycle 2. m1_rValid stays 0 throughout.
- Simultaneous requests after reset: m0 addr 0x0020, m1 addr 0x0030 held valid -> m0 granted first (prio=0) and gets line 2, then m1 is granted at the next IDLE and gets line 3. prio==0 after both complete.
- Fairness: m0 reasserts immediately after each completion while m1 is continuously valid, for 4 transactions -> grant order m0, m1, m0, m1.
- Backpressure: m1 owner, m1_rReady=0 for 3 cycles after rValid -> s_rReady=0, state stays DATA, rData stable. Completion and return to IDLE occur on the cycle m1_rReady rises.
- Mid-transaction reset: rst=0 for 1 cycle while in DATA -> next cycle busy=0, m0_rValid=m1_rValid=0, s_arValid=0, prio=0. A following m1 request completes normally.
- Idle hold-off: m1_arValid asserted while busy serving m0 -> m1_arReady stays 0 until the IDLE cycle, then 1 for exactly one cycle.

Source files
------------

// File: rtl/ram_rd_arbiter_if.sv
// Read-channel bundle between the two requesting masters, the arbiter and
// the single-port RAM. The master modport is the arbiter's view: it serves
// both requesters and acts as the only master toward the RAM. The slave
// modport is the surrounding system's view: the requesters and the RAM.
interface ram_rd_arbiter_if #(
  parameter int DW = 128,
  parameter int AW = 16
);
  // master 0 (instruction fetch)
  logic          m0_arValid;
  logic          m0_arReady;
  logic [AW-1:0] m0_arAddr;
  logic          m0_rValid;
  logic          m0_rReady;
  logic [DW-1:0] m0_rData;

  // master 1 (data/load)
  logic          m1_arValid;
  logic          m1_arReady;
  logic [AW-1:0] m1_arAddr;
  logic          m1_rValid;
  logic          m1_rReady;
  logic [DW-1:0] m1_rData;

  // RAM slave port
  logic          s_arValid;
  logic          s_arReady;
  logic [AW-1:0] s_arAddr;
  logic          s_rValid;
  logic          s_rReady;
  logic [DW-1:0] s_rData;

  modport master (
    input  m0_arValid, m0_arAddr, m0_rReady,
    output m0_arReady, m0_rValid, m0_rData,
    input  m1_arValid, m1_arAddr, m1_rReady,
    output m1_arReady, m1_rValid, m1_rData,
    output s_arValid, s_arAddr, s_rReady,
    input  s_arReady, s_rValid, s_rData
  );

  modport slave (
    output m0_arValid, m0_arAddr, m0_rReady,
    input  m0_arReady, m0_rValid, m0_rData,
    output m1_arValid, m1_arAddr, m1_rReady,
    input  m1_arReady, m1_rValid, m1_rData,
    input  s_arValid, s_arAddr, s_rReady,
    output s_arReady, s_rValid, s_rData
  );
endinterface

// File: rtl/ram_rd_arbiter.sv
// Two-requester round-robin read arbiter in front of the single-port RAM.
// One transaction is in flight at a time: a request is granted in IDLE,
// its address is presented to the RAM in ADDR, and the single returned
// beat is steered back to the owning master in DATA. The master that just
// completed drops to the lowest priority.
module ram_rd_arbiter #(
  parameter int DW = 128,
  parameter int AW = 16
) (
  input  logic                clk,
  input  logic                rst,
  ram_rd_arbiter_if.master    bus,
  output logic                busy,
  output logic                owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_owner;
  logic          r_prio;
  logic [AW-1:0] r_addr;

  logic          w_anyReq;
  logic          w_winner;
  logic          w_ownerReady;
  logic          w_rDone;
  logic [DW-1:0] w_rData;

  // Grant decision: a lone requester always wins, a tie goes to r_prio.
  always_comb begin
    w_anyReq = bus.m0_arValid | bus.m1_arValid;
    w_winner = 1'b0;
    if (bus.m0_arValid && bus.m1_arValid) begin
      w_winner = r_prio;
    end else if (bus.m1_arValid) begin
      w_winner = 1'b1;
    end
  end

  assign bus.m0_arReady = (r_state == IDLE) & w_anyReq & ~w_winner;
  assign bus.m1_arReady = (r_state == IDLE) & w_anyReq &  w_winner;

  assign bus.s_arValid = (r_state == ADDR);
  assign bus.s_arAddr  = r_addr;

  // Only the owner sees the beat and only its ready reaches the RAM.
  assign w_ownerReady  = r_owner ? bus.m1_rReady : bus.m0_rReady;
  assign bus.s_rReady  = (r_state == DATA) & w_ownerReady;
  assign bus.m0_rValid = (r_state == DATA) & ~r_owner & bus.s_rValid;
  assign bus.m1_rValid = (r_state == DATA) &  r_owner & bus.s_rValid;
  assign w_rDone       = bus.s_rValid & bus.s_rReady;

  // Read data fans out to both masters; rValid alone qualifies it.
  assign w_rData      = bus.s_rData;
  assign bus.m0_rData = w_rData;
  assign bus.m1_rData = w_rData;

  assign busy  = (r_state != IDLE);
  assign owner = r_owner;

  // Transaction sequencing, owner/address capture and round-robin update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_state <= ADDR;
            r_owner <= w_winner;
            r_addr  <= w_winner ? bus.m1_arAddr : bus.m0_arAddr;
          end
        end
        ADDR: begin
          if (bus.s_arReady) begin
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_rDone) begin
            r_state <= IDLE;
            r_prio  <= ~r_owner;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// Directed bench for ram_rd_arbiter with a small behavioural RAM whose
// line k holds the byte (0xA9 + k) repeated across all 16 bytes.
module tb_ram_rd_arbiter;

  localparam int DW = 128;
  localparam int AW = 16;

  logic clk;
  logic rst;
  logic busy;
  logic owner;

  int errors = 0;
  int checks = 0;

  ram_rd_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  ram_rd_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .owner (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected contents of RAM line k.
  function automatic logic [DW-1:0] lineVal(input int k);
    logic [7:0] b;
    b = 8'(8'hA9 + k);
    return {16{b}};
  endfunction

  // RAM model: accepts an address whenever idle, returns the line one
  // cycle later and holds it until rReady; reset shares the arbiter's.
  logic          ramBusy;
  logic          ramRValid;
  logic [DW-1:0] ramRData;

  assign bus.s_arReady = ~ramBusy;
  assign bus.s_rValid  = ramRValid;
  assign bus.s_rData   = ramRData;

  always @(posedge clk) begin
    if (!rst) begin
      ramBusy   <= 1'b0;
      ramRValid <= 1'b0;
      ramRData  <= '0;
    end else if (!ramBusy && bus.s_arValid) begin
      ramBusy   <= 1'b1;
      ramRValid <= 1'b1;
      ramRData  <= lineVal(int'(bus.s_arAddr >> 4));
    end else if (ramRValid && bus.s_rReady) begin
      ramBusy   <= 1'b0;
      ramRValid <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction with both rReady high; entered and left at
  // posedge+4 of an IDLE cycle.
  task automatic applyStimulus(input logic m0v, input logic m1v,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic expOwner, input logic [AW-1:0] expAddr);
    bus.m0_arValid = m0v;
    bus.m1_arValid = m1v;
    bus.m0_arAddr  = a0;
    bus.m1_arAddr  = a1;
    bus.m0_rReady  = 1'b1;
    bus.m1_rReady  = 1'b1;
    #3;
    checkOutput("grant m0_arReady", DW'(bus.m0_arReady), DW'(!expOwner));
    checkOutput("grant m1_arReady", DW'(bus.m1_arReady), DW'(expOwner));
    cyc();
    bus.m0_arValid = 1'b0;
    bus.m1_arValid = 1'b0;
    #3;
    checkOutput("addr busy", DW'(busy), DW'(1'b1));
    checkOutput("addr owner", DW'(owner), DW'(expOwner));
    checkOutput("addr s_arValid", DW'(bus.s_arValid), DW'(1'b1));
    checkOutput("addr s_arAddr", DW'(bus.s_arAddr), DW'(expAddr));
    cyc();
    #3;
    checkOutput("data m0_rValid", DW'(bus.m0_rValid), DW'(!expOwner));
    checkOutput("data m1_rValid", DW'(bus.m1_rValid), DW'(expOwner));
    checkOutput("data rData", expOwner ? bus.m1_rData : bus.m0_rData,
                lineVal(int'(expAddr >> 4)));
    cyc();
    #3;
    checkOutput("done busy", DW'(busy), DW'(1'b0));
  endtask

  typedef struct {
    logic m0v;
    logic m1v;
    logic exp0;
    logic exp1;
  } grantVec_t;

  typedef struct {
    logic          m0v;
    logic          m1v;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic          expOwner;
    logic [AW-1:0] expAddr;
  } txnVec_t;

  grantVec_t gv[4];
  txnVec_t   tv[6];

  initial begin
    // Grant decode while held in reset (IDLE, prio 0).
    gv[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    gv[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    gv[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    gv[3] = '{1'b1, 1'b1, 1'b1, 1'b0};
    // Round-robin sequence from prio 0; comments give prio before each.
    tv[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0010}; // p0
    tv[1] = '{1'b1, 1'b1, 16'h0020, 16'h0030, 1'b1, 16'h0030}; // p1
    tv[2] = '{1'b1, 1'b1, 16'h0040, 16'h0050, 1'b0, 16'h0040}; // p0
    tv[3] = '{1'b0, 1'b1, 16'h0000, 16'h0060, 1'b1, 16'h0060}; // p1
    tv[4] = '{1'b1, 1'b0, 16'h0070, 16'h0000, 1'b0, 16'h0070}; // p0
    tv[5] = '{1'b1, 1'b1, 16'h0080, 16'h0090, 1'b1, 16'h0090}; // p1

    rst = 1'b0;
    bus.m0_arValid = 1'b0;
    bus.m1_arValid = 1'b0;
    bus.m0_arAddr  = '0;
    bus.m1_arAddr  = '0;
    bus.m0_rReady  = 1'b1;
    bus.m1_rReady  = 1'b1;
    cyc();
    cyc();

    checkOutput("reset busy", DW'(busy), DW'(1'b0));
    checkOutput("reset s_arValid", DW'(bus.s_arValid), DW'(1'b0));
    checkOutput("reset s_rReady", DW'(bus.s_rReady), DW'(1'b0));
    checkOutput("reset m0_rValid", DW'(bus.m0_rValid), DW'(1'b0));
    checkOutput("reset m1_rValid", DW'(bus.m1_rValid), DW'(1'b0));

    for (int i = 0; i < 4; i++) begin
      bus.m0_arValid = gv[i].m0v;
      bus.m1_arValid = gv[i].m1v;
      #2;
      checkOutput($sformatf("reset grant[%0d] m0_arReady", i),
                  DW'(bus.m0_arReady), DW'(gv[i].exp0));
      checkOutput($sformatf("reset grant[%0d] m1_arReady", i),
                  DW'(bus.m1_arReady), DW'(gv[i].exp1));
    end
    bus.m0_arValid = 1'b0;
    bus.m1_arValid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    #3;

    // Table of full transactions exercising round-robin rotation.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(tv[i].m0v, tv[i].m1v, tv[i].a0, tv[i].a1,
                    tv[i].expOwner, tv[i].expAddr);
    end

    // Fairness: both held valid continuously, prio 0 -> m0, m1, m0, m1.
    bus.m0_arValid = 1'b1;
    bus.m1_arValid = 1'b1;
    bus.m0_arAddr  = 16'h0020;
    bus.m1_arAddr  = 16'h0030;
    for (int k = 0; k < 4; k++) begin
      logic expO;
      expO = 1'(k % 2);
      #3;
      checkOutput($sformatf("fair[%0d] m0_arReady", k), DW'(bus.m0_arReady), DW'(!expO));
      checkOutput($sformatf("fair[%0d] m1_arReady", k), DW'(bus.m1_arReady), DW'(expO));
      cyc();
      #3;
      checkOutput($sformatf("fair[%0d] owner", k), DW'(owner), DW'(expO));
      checkOutput($sformatf("fair[%0d] m0_arReady busy", k), DW'(bus.m0_arReady), DW'(1'b0));
      cyc();
      #3;
      checkOutput($sformatf("fair[%0d] rData", k), expO ? bus.m1_rData : bus.m0_rData,
                  lineVal(expO ? 3 : 2));
      cyc();
    end
    bus.m0_arValid = 1'b0;
    bus.m1_arValid = 1'b0;
    #3;

    // Idle hold-off: m1 requests while m0 is being served.
    bus.m0_arValid = 1'b1;
    bus.m0_arAddr  = 16'h0010;
    #3;
    checkOutput("hold m0_arReady", DW'(bus.m0_arReady), DW'(1'b1));
    cyc();
    bus.m0_arValid = 1'b0;
    bus.m1_arValid = 1'b1;
    bus.m1_arAddr  = 16'h0050;
    #3;
    checkOutput("hold m1_arReady addr", DW'(bus.m1_arReady), DW'(1'b0));
    cyc();
    #3;
    checkOutput("hold m1_arReady data", DW'(bus.m1_arReady), DW'(1'b0));
    checkOutput("hold m0_rValid", DW'(bus.m0_rValid), DW'(1'b1));
    checkOutput("hold m1_rValid", DW'(bus.m1_rValid), DW'(1'b0));
    cyc();
    #3;
    checkOutput("hold m1_arReady idle", DW'(bus.m1_arReady), DW'(1'b1));
    cyc();
    bus.m1_arValid = 1'b0;
    #3;
    checkOutput("hold m1_arReady after", DW'(bus.m1_arReady), DW'(1'b0));
    checkOutput("hold owner", DW'(owner), DW'(1'b1));
    cyc();
    #3;
    checkOutput("hold m1 rData", bus.m1_rData, lineVal(5));
    cyc();
    #3;

    // Backpressure: m1 owns and stalls for three cycles; m0_rReady ignored.
    bus.m1_arValid = 1'b1;
    bus.m1_arAddr  = 16'h0030;
    bus.m1_rReady  = 1'b0;
    bus.m0_rReady  = 1'b1;
    cyc();
    bus.m1_arValid = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      #3;
      checkOutput($sformatf("bp[%0d] s_rReady", k), DW'(bus.s_rReady), DW'(1'b0));
      checkOutput($sformatf("bp[%0d] m1_rValid", k), DW'(bus.m1_rValid), DW'(1'b1));
      checkOutput($sformatf("bp[%0d] m1_rData", k), bus.m1_rData, lineVal(3));
      checkOutput($sformatf("bp[%0d] busy", k), DW'(busy), DW'(1'b1));
      cyc();
    end
    bus.m1_rReady = 1'b1;
    #3;
    checkOutput("bp release s_rReady", DW'(bus.s_rReady), DW'(1'b1));
    cyc();
    #3;
    checkOutput("bp done busy", DW'(busy), DW'(1'b0));

    // Make prio 1 so a reset back to prio 0 is observable.
    applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0040);

    // Mid-transaction reset while m0 stalls in DATA.
    bus.m0_arValid = 1'b1;
    bus.m0_arAddr  = 16'h0060;
    bus.m0_rReady  = 1'b0;
    cyc();
    bus.m0_arValid = 1'b0;
    cyc();
    #3;
    checkOutput("mrst in data", DW'(bus.m0_rValid), DW'(1'b1));
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    #3;
    checkOutput("mrst busy", DW'(busy), DW'(1'b0));
    checkOutput("mrst m0_rValid", DW'(bus.m0_rValid), DW'(1'b0));
    checkOutput("mrst m1_rValid", DW'(bus.m1_rValid), DW'(1'b0));
    checkOutput("mrst s_arValid", DW'(bus.s_arValid), DW'(1'b0));
    // Tie after reset must go to m0 (prio back to 0).
    applyStimulus(1'b1, 1'b1, 16'h0070, 16'h0080, 1'b0, 16'h0070);
    applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0020, 1'b1, 16'h0020);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
